// File: rtl/systolic_skew_feeder.sv
// Vector FIFO feeding the systolic array edge with diagonal skew (lane i delayed i cycles) plus PE clear/pass-done pulses.
// pe_clear leads the first pop by one cycle; lane i of vector k lands at t0+2+k+i; in_ready = !full. Optional stats: FEEDER_STATS_EN.
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ARRAY_DIM  = 4,
  parameter int DEPTH      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] in_vec,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] edge_out,
  output logic [ARRAY_DIM-1:0]            edge_valid,
  output logic                            pe_clear,
  output logic                            pass_done,
  output logic                            err_overflow
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]                     pass_count
`endif
);

  localparam int VW = ARRAY_DIM * DATA_WIDTH;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'((ARRAY_DIM > 1) ? ARRAY_DIM - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [VW-1:0]   r_mem_vec [DEPTH];
  logic [DEPTH-1:0] r_mem_last;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_pending;
  logic [FW-1:0]   r_flush_cnt;
  logic            r_err;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_pop_last;
  logic [VW-1:0]   w_head;

  assign w_full     = (r_count == FULL_CNT);
  assign in_ready   = ~rst & ~w_full;
  assign w_push     = in_valid & in_ready;
  assign w_pop      = (r_state == S_STREAM);
  assign w_head     = r_mem_vec[r_rd_ptr];
  assign w_pop_last = w_pop & r_mem_last[r_rd_ptr];

  // Storage is deliberately unreset; occupancy lives in r_count/r_pending.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_vec[r_wr_ptr]  <= in_vec;
      r_mem_last[r_wr_ptr] <= in_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case ({w_push & in_last, w_pop_last})
        2'b10:   r_pending <= r_pending + CW'(1);
        2'b01:   r_pending <= r_pending - CW'(1);
        default: r_pending <= r_pending;
      endcase
      // A full FIFO without a pass terminator can never drain.
      if (w_full && (r_pending == '0)) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= (r_state == S_FLUSH) ? r_flush_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (r_pending != '0) w_state_nxt = S_CLEAR;
      S_CLEAR:  w_state_nxt = S_STREAM;
      S_STREAM: if (w_pop_last) w_state_nxt = (ARRAY_DIM > 1) ? S_FLUSH : S_DONE;
      S_FLUSH:  if (r_flush_cnt == FLUSH_LAST) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // pass_done lines up with the final element on lane ARRAY_DIM-1.
  assign pe_clear     = (r_state == S_CLEAR);
  assign pass_done    = (r_state == S_DONE);
  assign err_overflow = r_err;

  for (genvar gi = 0; gi < ARRAY_DIM; gi++) begin : g_lane
    logic [gi:0][DATA_WIDTH-1:0] r_dly;
    logic [gi:0]                 r_vdly;
    logic [DATA_WIDTH-1:0]       w_lane;

    assign w_lane = w_pop ? w_head[gi*DATA_WIDTH +: DATA_WIDTH] : '0;

    if (gi == 0) begin : g_first
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_dly  <= '0;
          r_vdly <= '0;
        end else begin
          r_dly  <= w_lane;
          r_vdly <= w_pop;
        end
      end
    end else begin : g_rest
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_dly  <= '0;
          r_vdly <= '0;
        end else begin
          r_dly  <= {r_dly[gi-1:0], w_lane};
          r_vdly <= {r_vdly[gi-1:0], w_pop};
        end
      end
    end

    assign edge_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_dly[gi];
    assign edge_valid[gi]                        = r_vdly[gi];
  end

`ifdef FEEDER_STATS_EN
  logic [15:0] r_pass_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pass_count <= '0;
    else if (r_state == S_DONE) r_pass_count <= r_pass_count + 16'd1;
  end

  assign pass_count = r_pass_count;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (DATA_WIDTH=32, ARRAY_DIM=4, DEPTH=8).
module tb_systolic_skew_feeder;
  localparam int DW = 32;
  localparam int AD = 4;
  localparam int DP = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [AD*DW-1:0] in_vec;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [AD*DW-1:0] edge_out;
  logic [AD-1:0]  edge_valid;
  logic           pe_clear;
  logic           pass_done;
  logic           err_overflow;
`ifdef FEEDER_STATS_EN
  logic [15:0]    pass_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] ev2 [0:9] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'he, 4'hc, 4'h8, 4'h0, 4'h0};

  systolic_skew_feeder #(.DATA_WIDTH(DW), .ARRAY_DIM(AD), .DEPTH(DP)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_vec       (in_vec),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .edge_out     (edge_out),
    .edge_valid   (edge_valid),
    .pe_clear     (pe_clear),
    .pass_done    (pass_done),
    .err_overflow (err_overflow)
`ifdef FEEDER_STATS_EN
    ,
    .pass_count   (pass_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AD*DW-1:0] mkvec(input int k);
    logic [AD*DW-1:0] v;
    for (int i = 0; i < AD; i++) v[i*DW +: DW] = 32'(k * 16 + i);
    return v;
  endfunction

  // Skewed edge image at cycle t0+c for a pass of K vectors built by mkvec(base+k).
  function automatic logic [AD*DW-1:0] exp_edge(input int c, input int kk, input int base);
    logic [AD*DW-1:0] v;
    v = '0;
    for (int i = 0; i < AD; i++) begin
      int k;
      k = c - 2 - i;
      if (k >= 0 && k < kk) v[i*DW +: DW] = 32'((base + k) * 16 + i);
    end
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input int budget, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (pe_clear) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    logic ok;
    logic flag;
    int   clr_q[$];
    int   done_q[$];
    logic [31:0] d_q[$];
    int   idx;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_vec = '0;
    #2;
    check("rst_edge_valid", edge_valid, 0);
    check("rst_edge_out", edge_out, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_flags", {pe_clear, pass_done, err_overflow}, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);

    // 1: reset while streaming
    in_valid = 1'b1; in_vec = mkvec(1); in_last = 1'b0; tick();
    in_vec = mkvec(2); in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    check("t1_clear", pe_clear, 1);
    tick(); tick();
    check("t1_lane0", {edge_valid, edge_out[DW-1:0]}, {4'h1, 32'h10});
    rst = 1'b1;
    #1;
    check("t1_rst_out", edge_out, 0);
    check("t1_rst_flags", {edge_valid, pe_clear, pass_done, err_overflow, in_ready}, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("t1_ready", in_ready, 1);
    flag = 1'b0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (pass_done || pe_clear || (edge_valid != 0)) flag = 1'b1;
    end
    check("t1_quiet", flag, 0);

    // 2: single pass K=3
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_vec = mkvec(k); in_last = (k == 2); tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_clear(10, ok);
    check("t2_clear_seen", ok, 1);
    for (int c = 1; c <= 9; c++) begin
      tick();
      check($sformatf("t2_valid_c%0d", c), edge_valid, ev2[c]);
      check($sformatf("t2_data_c%0d", c), edge_out, exp_edge(c, 3, 0));
      check($sformatf("t2_done_c%0d", c), {pass_done, pe_clear}, {(c == 7), 1'b0});
    end

    // 3: full FIFO with terminator on the 8th vector
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t3_ready_%0d", k), in_ready, 1);
      in_valid = 1'b1; in_vec = mkvec(k); in_last = (k == 7); tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("t3_full", in_ready, 0);
    wait_clear(10, ok);
    check("t3_clear_seen", ok, 1);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c >= 2 && c <= 9)
        check($sformatf("t3_lane0_c%0d", c), {edge_valid[0], edge_out[DW-1:0]}, {1'b1, 32'((c - 2) * 16)});
      if (c == 10) check("t3_lane0_end", edge_valid[0], 0);
    end
    check("t3_done_lane3", {pass_done, edge_valid[3], edge_out[3*DW +: DW]}, {2'b11, 32'h73});
    check("t3_no_err", err_overflow, 0);
    tick();

    // 4: full FIFO without terminator
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4_ready_%0d", k), in_ready, 1);
      in_valid = 1'b1; in_vec = mkvec(20 + k); in_last = 1'b0; tick();
    end
    check("t4_full", {in_ready, err_overflow}, 2'b00);
    tick();
    check("t4_err_set", err_overflow, 1);
    flag = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (pe_clear || in_ready) flag = 1'b1;
    end
    check("t4_stall", {flag, err_overflow}, 2'b01);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t4_err_rst", err_overflow, 0);
    tick();
    rst = 1'b0;
    #1;
    check("t4_ready_rel", in_ready, 1);

    // 5: three K=2 passes pushed back-to-back with in_valid held high
    idx = 0; flag = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (idx < 6) begin
        in_valid = 1'b1; in_vec = mkvec(8 + idx); in_last = (idx % 2 == 1);
        if (!in_ready) flag = 1'b1;
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      tick();
      if (in_valid) idx++;
      if (pe_clear) clr_q.push_back(cyc);
      if (pass_done) done_q.push_back(cyc);
      if (edge_valid[0]) d_q.push_back(edge_out[DW-1:0]);
    end
    in_valid = 1'b0;
    check("t5_ready_held", flag, 0);
    check("t5_clear_cnt", clr_q.size(), 3);
    check("t5_done_cnt", done_q.size(), 3);
    check("t5_data_cnt", d_q.size(), 6);
    if (clr_q.size() == 3 && done_q.size() == 3) begin
      for (int p = 0; p < 3; p++) begin
        check($sformatf("t5_clear_%0d", p), clr_q[p], 3 + 8 * p);
        check($sformatf("t5_done_%0d", p), done_q[p], 9 + 8 * p);
      end
    end
    if (d_q.size() == 6)
      for (int j = 0; j < 6; j++) check($sformatf("t5_lane0_%0d", j), d_q[j], (8 + j) * 16);

    // 6: gaps on in_valid before the terminator
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    flag = 1'b0;
    in_valid = 1'b1; in_vec = mkvec(40); in_last = 1'b0; tick();
    in_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (pe_clear || (edge_valid != 0)) flag = 1'b1;
    end
    in_valid = 1'b1; in_vec = mkvec(41); tick();
    in_valid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tick();
      if (pe_clear || (edge_valid != 0)) flag = 1'b1;
    end
    in_valid = 1'b1; in_vec = mkvec(42); in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("t6_no_early", flag, 0);
    wait_clear(10, ok);
    check("t6_clear_seen", ok, 1);
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("t6_valid_c%0d", c), edge_valid, ev2[c]);
      check($sformatf("t6_data_c%0d", c), edge_out, exp_edge(c, 3, 40));
    end
    check("t6_done", pass_done, 1);
    tick();
`ifdef FEEDER_STATS_EN
    check("t6_pass_count", pass_count, 1);
`endif
    check("t6_idle", {pass_done, edge_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
